// File: rtl/mpa_mips_regf.sv
// Multi-port MIPS register file with two write ports, a pending-write scoreboard and a zero-write error pulse.
// Optional write-to-read forwarding is compiled in when MPA_REGF_BYPASS_EN is defined.
module mpa_mips_regf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     CLK,
    input  logic                     HW_RSTn,
    input  logic [NUM_RD*ADDR_W-1:0] RA,
    output logic [NUM_RD*DATA_W-1:0] RD,
    output logic [NUM_RD-1:0]        RBUSY,
    input  logic                     WE0,
    input  logic [ADDR_W-1:0]        WA0,
    input  logic [DATA_W-1:0]        WD0,
    input  logic                     WE1,
    input  logic [ADDR_W-1:0]        WA1,
    input  logic [DATA_W-1:0]        WD1,
    input  logic                     RSV,
    input  logic [ADDR_W-1:0]        RSV_A,
    output logic                     ZERO_WR_ERR
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              zwe_q;
    logic              zwe_d;

    // Port 1 is applied after port 0 so it wins a collision; a reserve is applied last so it beats a clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (WE0 && (WA0 != '0)) begin
            regs_d[WA0] = WD0;
            busy_d[WA0] = 1'b0;
        end
        if (WE1 && (WA1 != '0)) begin
            regs_d[WA1] = WD1;
            busy_d[WA1] = 1'b0;
        end
        if (RSV && (RSV_A != '0)) begin
            busy_d[RSV_A] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        zwe_d     = (WE0 && (WA0 == '0)) || (WE1 && (WA1 == '0));
    end

    always_ff @(posedge CLK or negedge HW_RSTn) begin
        if (!HW_RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            zwe_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            zwe_q  <= zwe_d;
        end
    end

    assign ZERO_WR_ERR = zwe_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rb;
`ifdef MPA_REGF_BYPASS_EN
        logic              fwd;
`endif

        assign ra = RA[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = regs_q[ra];
            rb = busy_q[ra];
`ifdef MPA_REGF_BYPASS_EN
            fwd = 1'b0;
            if (ra != '0) begin
                if (WE0 && (WA0 == ra)) begin
                    rd  = WD0;
                    fwd = 1'b1;
                end
                if (WE1 && (WA1 == ra)) begin
                    rd  = WD1;
                    fwd = 1'b1;
                end
                // A same-cycle reserve keeps the stored busy bit visible to decode.
                if (fwd && !(RSV && (RSV_A == ra))) begin
                    rb = 1'b0;
                end
            end
`endif
            if (!HW_RSTn) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign RD[k*DATA_W +: DATA_W] = rd;
        assign RBUSY[k]               = rb;
    end

endmodule

// File: tb/tb_mpa_mips_regf.sv
// Directed bench for mpa_mips_regf: vector table plus hand sequences for same-cycle reads and async reset.
module tb_mpa_mips_regf;

    logic        CLK = 1'b0;
    logic        HW_RSTn;
    logic [9:0]  RA;
    logic [63:0] RD;
    logic [1:0]  RBUSY;
    logic        WE0, WE1, RSV;
    logic [4:0]  WA0, WA1, RSV_A;
    logic [31:0] WD0, WD1;
    logic        ZERO_WR_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    mpa_mips_regf #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .CLK(CLK), .HW_RSTn(HW_RSTn), .RA(RA), .RD(RD), .RBUSY(RBUSY),
        .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
        .RSV(RSV), .RSV_A(RSV_A), .ZERO_WR_ERR(ZERO_WR_ERR)
    );

    always #50 CLK = ~CLK;

    typedef struct {
        logic        we0; logic [4:0] wa0; logic [31:0] wd0;
        logic        we1; logic [4:0] wa1; logic [31:0] wd1;
        logic        rsv; logic [4:0] rsv_a;
        logic [4:0]  ra0; logic [4:0] ra1;
        logic [31:0] e_rd0; logic [31:0] e_rd1;
        logic        e_rb0; logic e_rb1; logic e_zerr;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        WE0 = 0; WA0 = 0; WD0 = 0; WE1 = 0; WA1 = 0; WD1 = 0; RSV = 0; RSV_A = 0;
    endtask

    initial begin
        //           we0 wa0  wd0            we1 wa1  wd1    rsv rsv_a ra0  ra1   rd0            rd1            rb0 rb1 zerr
        vt[0]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  0, 5'd0,  5'd5, 5'd0,  32'hDEADBEEF, 32'h0,         0, 0, 0};
        vt[1]  = '{1, 5'd7, 32'h11,       1, 5'd7, 32'h22, 0, 5'd0,  5'd7, 5'd5,  32'h22,       32'hDEADBEEF,  0, 0, 0};
        vt[2]  = '{1, 5'd0, 32'hFFFF,     0, 5'd0, 32'h0,  0, 5'd0,  5'd0, 5'd7,  32'h0,        32'h22,        0, 0, 1};
        vt[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0,  5'd0, 5'd5,  32'h0,        32'hDEADBEEF,  0, 0, 0};
        vt[4]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd9,  5'd9, 5'd7,  32'h0,        32'h22,        1, 0, 0};
        vt[5]  = '{0, 5'd0, 32'h0,        1, 5'd9, 32'h5,  0, 5'd0,  5'd9, 5'd3,  32'h5,        32'hABCD,      0, 0, 0};
        vt[6]  = '{1, 5'd9, 32'h77,       0, 5'd0, 32'h0,  1, 5'd9,  5'd9, 5'd5,  32'h77,       32'hDEADBEEF,  1, 0, 0};
        vt[7]  = '{1, 5'd0, 32'h1,        1, 5'd0, 32'h2,  0, 5'd0,  5'd9, 5'd9,  32'h77,       32'h77,        1, 1, 1};
        vt[8]  = '{1, 5'd12, 32'h1234,    0, 5'd0, 32'h0,  1, 5'd0,  5'd0, 5'd12, 32'h0,        32'h1234,      0, 0, 0};
        vt[9]  = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h3,  0, 5'd0,  5'd12, 5'd7, 32'h1234,     32'h22,        0, 0, 1};
        vt[10] = '{1, 5'd0, 32'h4,        0, 5'd0, 32'h0,  0, 5'd0,  5'd12, 5'd7, 32'h1234,     32'h22,        0, 0, 1};
        vt[11] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0,  5'd12, 5'd7, 32'h1234,     32'h22,        0, 0, 0};
        vt[12] = '{1, 5'd9, 32'h99,       0, 5'd0, 32'h0,  1, 5'd20, 5'd9, 5'd20, 32'h99,       32'h0,         0, 1, 0};
        vt[13] = '{1, 5'd7, 32'h33,       1, 5'd8, 32'h44, 0, 5'd0,  5'd7, 5'd8,  32'h33,       32'h44,        0, 0, 0};

        HW_RSTn = 0;
        idle();
        RA = {5'd5, 5'd0};
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_rd0", RD[31:0], 32'h0);
        chk("rst_rd1", RD[63:32], 32'h0);
        chk("rst_rbusy", {30'b0, RBUSY}, 32'h0);
        chk("rst_zerr", {31'b0, ZERO_WR_ERR}, 32'h0);
        @(negedge CLK);
        HW_RSTn = 1;

        // Same-cycle read of a register being written.
        @(negedge CLK);
        WE1 = 1; WA1 = 5'd3; WD1 = 32'hABCD; RA = {5'd0, 5'd3};
        #1;
`ifdef MPA_REGF_BYPASS_EN
        chk("same_cycle_rd", RD[31:0], 32'hABCD);
`else
        chk("same_cycle_rd", RD[31:0], 32'h0);
`endif
        @(posedge CLK);
        #1;
        idle();
        #1;
        chk("after_edge_rd", RD[31:0], 32'hABCD);

        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            WE0 = vt[i].we0; WA0 = vt[i].wa0; WD0 = vt[i].wd0;
            WE1 = vt[i].we1; WA1 = vt[i].wa1; WD1 = vt[i].wd1;
            RSV = vt[i].rsv; RSV_A = vt[i].rsv_a;
            RA  = {vt[i].ra1, vt[i].ra0};
            @(posedge CLK);
            #1;
            idle();
            #1;
            chk($sformatf("v%0d_rd0", i), RD[31:0], vt[i].e_rd0);
            chk($sformatf("v%0d_rd1", i), RD[63:32], vt[i].e_rd1);
            chk($sformatf("v%0d_rb0", i), {31'b0, RBUSY[0]}, {31'b0, vt[i].e_rb0});
            chk($sformatf("v%0d_rb1", i), {31'b0, RBUSY[1]}, {31'b0, vt[i].e_rb1});
            chk($sformatf("v%0d_zerr", i), {31'b0, ZERO_WR_ERR}, {31'b0, vt[i].e_zerr});
        end

`ifdef MPA_REGF_BYPASS_EN
        // reg 20 is still reserved from the table; forwarding hides busy unless re-reserved.
        @(negedge CLK);
        WE0 = 1; WA0 = 5'd20; WD0 = 32'h5151; RA = {5'd20, 5'd20};
        #1;
        chk("byp_rd", RD[31:0], 32'h5151);
        chk("byp_rb_clr", {31'b0, RBUSY[0]}, 32'h0);
        RSV = 1; RSV_A = 5'd20;
        #1;
        chk("byp_rb_rsv", {31'b0, RBUSY[0]}, 32'h1);
        @(posedge CLK);
        #1;
        idle();
`endif

        // Fill regs 1..31, reserve reg 4, then reset mid-cycle with a write and zero write pending.
        for (int a = 1; a < 32; a++) begin
            @(negedge CLK);
            WE0 = 1; WA0 = a[4:0]; WD0 = 32'hA5A5A5A5;
        end
        @(negedge CLK);
        idle();
        RSV = 1; RSV_A = 5'd4;
        @(negedge CLK);
        idle();
        WE0 = 1; WA0 = 5'd0; WD0 = 32'h1; WE1 = 1; WA1 = 5'd6; WD1 = 32'h1;
        RA = {5'd31, 5'd4};
        @(posedge CLK);
        #1;
        chk("pre_rst_rd", RD[31:0], 32'hA5A5A5A5);
        chk("pre_rst_rd31", RD[63:32], 32'hA5A5A5A5);
        chk("pre_rst_rb", {31'b0, RBUSY[0]}, 32'h1);
        chk("pre_rst_zerr", {31'b0, ZERO_WR_ERR}, 32'h1);
        #2;
        HW_RSTn = 0;
        for (int a = 0; a < 32; a++) begin
            RA = {a[4:0], a[4:0]};
            #1;
            chk($sformatf("rst_rd_%0d", a), RD[31:0], 32'h0);
            chk($sformatf("rst_rb_%0d", a), {30'b0, RBUSY}, 32'h0);
        end
        chk("rst_async_zerr", {31'b0, ZERO_WR_ERR}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        idle();
        HW_RSTn = 1;
        RA = {5'd4, 5'd6};
        #1;
        chk("post_rst_rd6", RD[31:0], 32'h0);
        chk("post_rst_rd4", RD[63:32], 32'h0);
        chk("post_rst_rb4", {31'b0, RBUSY[1]}, 32'h0);
        @(posedge CLK);
        #1;
        chk("post_rst_zerr", {31'b0, ZERO_WR_ERR}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mpa_mips_regf.md
# mpa_mips_regf

Parametrised multi-port register file for the MIPS core. It supports NUM_RD combinational read ports, two synchronous write ports with defined collision priority, and a per-register pending-write scoreboard for pipeline hazard detection. It sits between decode (reads, reservations) and write-back (writes), and serves as the drop-in generalisation of the 32x32 two-read / one-write file. Register 0 is hardwired to zero.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- CLK  in  1  clock, all state updates on rising edge
- HW_RSTn  in  1  reset; HW_RSTn asynchronous, active-low; clock CLK
- RA  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- RD  out  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
- RBUSY  out  NUM_RD  port k's register has a pending (reserved, unwritten) value
- WE0, WE1  in  1  write enables, ports 0 and 1
- WA0, WA1  in  ADDR_W  write addresses
- WD0, WD1  in  DATA_W  write data
- RSV  in  1  reserve request: mark register RSV_A pending
- RSV_A  in  ADDR_W  register to reserve
- ZERO_WR_ERR  out  1  one-cycle pulse: a write to register 0 was attempted

## Operation
- Storage: DEPTH x DATA_W flops plus DEPTH busy bits. Register 0 data and busy are constant 0.
- Write: at a rising edge, every port with WEn=1 and WAn!=0 loads WDn into reg[WAn] and clears busy[WAn].
- Write collision (WE0=WE1=1, WA0==WA1!=0): port 1 wins. Reg takes WD1; busy is cleared once.
- Reserve: at a rising edge with RSV=1 and RSV_A!=0, busy[RSV_A] is set. RSV_A==0 is ignored with no error.
- Reserve vs. write on the same register in the same cycle: the set wins (busy=1, data=written value). This covers back-to-back producers.
- Read: RD[k] = reg[RA[k]], combinational. RA[k]==0 returns 0. RBUSY[k] = busy[RA[k]].
- Zero write: WEn=1 with WAn==0 leaves state unchanged. ZERO_WR_ERR is set to 1 at the next edge and cleared at the following edge, unless a new zero write occurs. Either port alone, or both ports, produce one pulse.
- Registers not addressed hold their value.

## Timing
- Reset (asynchronous assert, synchronous-to-CLK deassert by the system): all regs 0, all busy 0, ZERO_WR_ERR 0. RD=0 and RBUSY=0 for all addresses while reset is asserted.
- Reset asserted mid-write or mid-reserve: the write or reserve is discarded, and the reset values hold.
- Write latency (bypass off): a value written at edge N is visible on RD from after edge N. A same-cycle read returns the old value.
- Reserve latency: RBUSY goes high from after edge N when RSV is sampled at edge N.
- Clear latency (bypass off): RBUSY drops from after the write edge.
- ZERO_WR_ERR: registered, high for exactly the cycle after each offending cycle.
- No handshake or backpressure: every request is accepted every cycle.

## Configuration
- MPA_REGF_BYPASS_EN defined: write-to-read forwarding is enabled.
  - If WEn=1, WAn==RA[k], and RA[k]!=0 in the current cycle, RD[k] returns WDn combinationally, with port 1 taking priority over port 0.
  - RBUSY[k] is forced to 0 in that cycle, unless RSV=1 with RSV_A==RA[k] in the same cycle; in that case RBUSY[k] stays at the stored busy value.
  - Zero-register reads are never forwarded.
- Not defined: there is no forwarding. Reads and busy reflect stored state only, per Timing.

## Test plan
- Reset, then write WA0=5 WD0=0xDEADBEEF and read RA[0]=5 next cycle -> RD[0]=0xDEADBEEF. RA[1]=0 -> RD[1]=0.
- Same cycle, WE0/WE1 both to reg 7 with WD0=0x11, WD1=0x22 -> reg7=0x22. Any other address is unchanged.
- WE0=1, WA0=0, WD0=0xFFFF -> reg0 reads 0. ZERO_WR_ERR=1 for exactly one cycle.
- RSV with RSV_A=9 -> RBUSY=1 on RA=9 next cycle. Then write reg9=0x5 -> RBUSY=0 and RD=0x5 next cycle. In the same cycle, write reg9 plus RSV reg9 -> RBUSY stays 1 and RD=written value.
- With MPA_REGF_BYPASS_EN: WA1=3, WD1=0xABCD, RA[0]=3 in the same cycle -> RD[0]=0xABCD that cycle. Without the macro -> old value (0 after reset).
- Assert HW_RSTn low mid-cycle after regs 1..31 are loaded with 0xA5A5A5A5 -> all reads are 0, all RBUSY are 0, and ZERO_WR_ERR=0 immediately, without waiting for a CLK edge.
